// File: rtl/axis_bram_adapter_v2_0_cntl.sv
// rtl/axis_bram_adapter_v2_0_cntl.sv - AXIS to BRAM line packing / unpacking controller
module axis_bram_adapter_v2_0_cntl #(
   parameter int WORD_WIDTH     = 32,
   parameter int WORDS_PER_LINE = 36,
   parameter int ADDR_WIDTH     = 9
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 start,
   input  logic                                 mode,
   input  logic [ADDR_WIDTH-1:0]                base_addr,
   input  logic [ADDR_WIDTH:0]                  line_count,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 protocol_err,
   input  logic [WORD_WIDTH-1:0]                s_axis_tdata,
   input  logic                                 s_axis_tvalid,
   input  logic                                 s_axis_tlast,
   output logic                                 s_axis_tready,
   output logic [WORD_WIDTH-1:0]                m_axis_tdata,
   output logic                                 m_axis_tvalid,
   output logic                                 m_axis_tlast,
   input  logic                                 m_axis_tready,
   output logic                                 bram_en,
   output logic                                 bram_we,
   output logic [ADDR_WIDTH-1:0]                bram_addr,
   output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] bram_wdata,
   input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] bram_rdata
);

   localparam int LINE_WIDTH = WORD_WIDTH * WORDS_PER_LINE;
   localparam int WIDX_W     = $clog2(WORDS_PER_LINE);
   localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS_PER_LINE - 1);

   typedef enum logic [2:0] {
      IDLE,
      WR_FILL,
      WR_COMMIT,
      RD_ISSUE,
      RD_WAIT,
      RD_DRAIN,
      DONE
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [ADDR_WIDTH:0]     count_q;
   logic [ADDR_WIDTH:0]     line_idx_q;
   logic [WIDX_W-1:0]       word_idx_q;
   logic [LINE_WIDTH-1:0]   line_q;
   logic                    err_q;

   logic                    final_line;
   logic                    last_word;

   // line_count is latched non-zero, so count_q - 1 never underflows while a line is moving
   assign final_line = (line_idx_q == (count_q - 1'b1));
   assign last_word  = (word_idx_q == LAST_WORD);

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-state handshake / BRAM strobes
   always_comb begin
      state_d       = state_q;
      busy          = 1'b1;
      done          = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      bram_en       = 1'b0;
      bram_we       = 1'b0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (line_count == '0) begin
                  state_d = DONE;
               end else if (mode) begin
                  state_d = WR_FILL;
               end else begin
                  state_d = RD_ISSUE;
               end
            end
         end
         WR_FILL: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && last_word) begin
               state_d = WR_COMMIT;
            end
         end
         WR_COMMIT: begin
            bram_en = 1'b1;
            bram_we = 1'b1;
            state_d = final_line ? DONE : WR_FILL;
         end
         RD_ISSUE: begin
            bram_en = 1'b1;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            state_d = RD_DRAIN;
         end
         RD_DRAIN: begin
            m_axis_tvalid = 1'b1;
            if (m_axis_tready && last_word) begin
               state_d = final_line ? DONE : RD_ISSUE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Transfer parameters, word/line counters, line buffer and tlast checker
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         base_q     <= '0;
         count_q    <= '0;
         line_idx_q <= '0;
         word_idx_q <= '0;
         line_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start && (line_count != '0)) begin
                  base_q     <= base_addr;
                  count_q    <= line_count;
                  line_idx_q <= '0;
                  word_idx_q <= '0;
               end
            end
            WR_FILL: begin
               if (s_axis_tvalid) begin
                  line_q[word_idx_q*WORD_WIDTH +: WORD_WIDTH] <= s_axis_tdata;
                  err_q      <= (s_axis_tlast != (final_line && last_word));
                  word_idx_q <= last_word ? '0 : word_idx_q + 1'b1;
               end
            end
            WR_COMMIT: begin
               line_idx_q <= line_idx_q + 1'b1;
            end
            RD_WAIT: begin
               line_q <= bram_rdata;
            end
            RD_DRAIN: begin
               if (m_axis_tready) begin
                  word_idx_q <= last_word ? '0 : word_idx_q + 1'b1;
                  if (last_word) begin
                     line_idx_q <= line_idx_q + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Address wraps naturally at 2^ADDR_WIDTH; data buses are quiet outside their phases
   assign bram_addr    = base_q + line_idx_q[ADDR_WIDTH-1:0];
   assign bram_wdata   = (state_q == WR_COMMIT) ? line_q : '0;
   assign m_axis_tdata = (state_q == RD_DRAIN) ? line_q[word_idx_q*WORD_WIDTH +: WORD_WIDTH] : '0;
   assign m_axis_tlast = (state_q == RD_DRAIN) && final_line && last_word;
   assign protocol_err = err_q;

endmodule

// File: tb/tb_axis_bram_adapter_v2_0_cntl.sv
// tb/tb_axis_bram_adapter_v2_0_cntl.sv - scoreboard bench for axis_bram_adapter_v2_0_cntl
module tb_axis_bram_adapter_v2_0_cntl;

   localparam int WW  = 8;
   localparam int WPL = 4;
   localparam int AW  = 4;
   localparam int LW  = WW * WPL;

   logic            clk = 1'b0;
   logic            rstn;
   logic            start;
   logic            mode;
   logic [AW-1:0]   base_addr;
   logic [AW:0]     line_count;
   logic            busy;
   logic            done;
   logic            protocol_err;
   logic [WW-1:0]   s_tdata;
   logic            s_tvalid;
   logic            s_tlast;
   logic            s_tready;
   logic [WW-1:0]   m_tdata;
   logic            m_tvalid;
   logic            m_tlast;
   logic            m_tready;
   logic            bram_en;
   logic            bram_we;
   logic [AW-1:0]   bram_addr;
   logic [LW-1:0]   bram_wdata;
   logic [LW-1:0]   bram_rdata;

   always #5 clk = ~clk;

   axis_bram_adapter_v2_0_cntl #(
      .WORD_WIDTH(WW), .WORDS_PER_LINE(WPL), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .mode(mode),
      .base_addr(base_addr), .line_count(line_count),
      .busy(busy), .done(done), .protocol_err(protocol_err),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
      .m_axis_tready(m_tready),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [LW-1:0] data;
   } wr_t;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            wr_count = 0;
   int            en_count = 0;
   int            done_count = 0;
   int            err_count = 0;
   int            last_wr_cyc = 0;
   int            done_cyc = 0;
   int            rdy_mode = 0;
   wr_t           wr_q[$];
   logic [WW:0]   rd_q[$];
   logic [LW-1:0] mem[16];
   logic [LW-1:0] ref_mem[16];
   logic [WW-1:0] bd[$];
   bit            bl[$];
   wr_t           mon_w;
   logic [WW:0]   mon_r;
   bit            hold_valid = 0;
   logic [WW-1:0] hold_data;
   logic          hold_last;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // BRAM model: synchronous write, one-cycle read latency
   always @(posedge clk) begin
      if (bram_en && bram_we) mem[bram_addr] = bram_wdata;
      if (bram_en && !bram_we) bram_rdata <= mem[bram_addr];
   end

   // Monitor: pops scoreboard entries whenever the DUT presents a write or a beat
   always @(negedge clk) begin
      if (rstn) begin
         if (bram_en) en_count++;
         if (bram_en && bram_we) begin
            wr_count++;
            last_wr_cyc = cyc;
            if (wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write actual=addr %0h required=no write", bram_addr);
            end else begin
               mon_w = wr_q.pop_front();
               chk("wr_addr", 64'(bram_addr), 64'(mon_w.addr));
               chk("wr_data", 64'(bram_wdata), 64'(mon_w.data));
            end
         end
         if (done) begin
            done_count++;
            done_cyc = cyc;
         end
         if (protocol_err) err_count++;
         if (m_tvalid) begin
            if (hold_valid) begin
               chk("stall_data", 64'(m_tdata), 64'(hold_data));
               chk("stall_last", 64'(m_tlast), 64'(hold_last));
            end
            if (m_tready) begin
               hold_valid = 0;
               if (rd_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_beat actual=%0h required=no beat", m_tdata);
               end else begin
                  mon_r = rd_q.pop_front();
                  chk("rd_data", 64'(m_tdata), 64'(mon_r[WW-1:0]));
                  chk("rd_last", 64'(m_tlast), 64'(mon_r[WW]));
               end
            end else begin
               hold_valid = 1;
               hold_data  = m_tdata;
               hold_last  = m_tlast;
            end
         end else begin
            hold_valid = 0;
         end
      end else begin
         hold_valid = 0;
      end
   end

   // Output-stream backpressure: always ready, alternating, or random
   initial begin
      m_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_done"}, 64'(done), 0);
      chk({tag, "_perr"}, 64'(protocol_err), 0);
      chk({tag, "_s_tready"}, 64'(s_tready), 0);
      chk({tag, "_m_tvalid"}, 64'(m_tvalid), 0);
      chk({tag, "_m_tlast"}, 64'(m_tlast), 0);
      chk({tag, "_m_tdata"}, 64'(m_tdata), 0);
      chk({tag, "_bram_en"}, 64'(bram_en), 0);
      chk({tag, "_bram_we"}, 64'(bram_we), 0);
      chk({tag, "_bram_addr"}, 64'(bram_addr), 0);
      chk({tag, "_bram_wdata"}, 64'(bram_wdata), 0);
   endtask

   task automatic start_xfer(input bit md, input logic [AW-1:0] b, input logic [AW:0] n);
      @(posedge clk); #1;
      start = 1'b1; mode = md; base_addr = b; line_count = n;
      @(posedge clk); #1;
      start = 1'b0;
      base_addr = $urandom; line_count = $urandom;
   endtask

   task automatic send_beat(input logic [WW-1:0] d, input bit l, input int gap);
      bit acc;
      repeat (gap) begin @(posedge clk); #1; end
      s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
      acc = 0;
      for (int k = 0; k < 100 && !acc; k++) begin
         @(negedge clk); acc = s_tready;
         @(posedge clk); #1;
      end
      if (!acc) begin
         checks++; errors++;
         $display("FAIL beat_accept_timeout actual=not accepted required=accepted");
      end
      s_tvalid = 1'b0;
      s_tdata = $urandom; s_tlast = 1'($urandom);
   endtask

   task automatic wait_done(input string tag);
      bit seen = 0;
      for (int k = 0; k < 1000 && !seen; k++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL %s_done_timeout actual=no done required=done", tag);
      end
      @(posedge clk); #1;
   endtask

   // Reference: beats pack little-word-first into lines at (base+i) mod 16
   task automatic run_write(input string tag, input logic [AW-1:0] b, input int n, input int max_gap);
      int e_err = 0;
      int d0 = done_count;
      int p0 = err_count;
      int total = n * WPL;
      logic [LW-1:0] line;
      wr_t w;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < WPL; k++) line[k*WW +: WW] = bd[i*WPL + k];
         w.addr = AW'(int'(b) + i);
         w.data = line;
         wr_q.push_back(w);
         ref_mem[w.addr] = line;
      end
      for (int j = 0; j < total; j++) if (bl[j] != (j == total - 1)) e_err++;
      start_xfer(1'b1, b, (AW+1)'(n));
      for (int j = 0; j < total; j++) send_beat(bd[j], bl[j], $urandom_range(0, max_gap));
      wait_done(tag);
      chk({tag, "_done_cnt"}, 64'(done_count - d0), 1);
      chk({tag, "_perr_cnt"}, 64'(err_count - p0), 64'(e_err));
      chk({tag, "_wr_pending"}, 64'(wr_q.size()), 0);
   endtask

   task automatic run_read(input string tag, input logic [AW-1:0] b, input int n);
      int d0 = done_count;
      logic [LW-1:0] line;
      for (int i = 0; i < n; i++) begin
         line = ref_mem[AW'(int'(b) + i)];
         for (int k = 0; k < WPL; k++)
            rd_q.push_back({1'((i == n - 1) && (k == WPL - 1)), line[k*WW +: WW]});
      end
      start_xfer(1'b0, b, (AW+1)'(n));
      wait_done(tag);
      chk({tag, "_done_cnt"}, 64'(done_count - d0), 1);
      chk({tag, "_rd_pending"}, 64'(rd_q.size()), 0);
   endtask

   task automatic fill_beats(input int total, input int flip_pct);
      bd.delete(); bl.delete();
      for (int j = 0; j < total; j++) begin
         bd.push_back(WW'($urandom));
         bl.push_back((j == total - 1) ^ ($urandom_range(0, 99) < flip_pct));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int en0, d0, wr0, n;
      logic [LW-1:0] v;
      rstn = 1'b1; start = 0; mode = 0; base_addr = 0; line_count = 0;
      s_tdata = 0; s_tvalid = 0; s_tlast = 0;
      for (int i = 0; i < 16; i++) begin
         v = $urandom; mem[i] = v; ref_mem[i] = v;
      end
      mem[15] = 32'hDDCCBBAA; ref_mem[15] = 32'hDDCCBBAA;
      mem[0]  = 32'h44332211; ref_mem[0]  = 32'h44332211;
      #1 rstn = 1'b0;
      #1 check_outputs_zero("reset");
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      // Two lines at base 3 from beats 01..08, continuous
      bd.delete(); bl.delete();
      for (int j = 0; j < 8; j++) begin bd.push_back(WW'(j + 1)); bl.push_back(j == 7); end
      run_write("wr2", 4'd3, 2, 0);
      chk("wr2_done_after_commit", 64'(done_cyc - last_wr_cyc), 1);

      // Read one then two lines at base 15 (wraps to 0)
      rdy_mode = 0;
      run_read("rd1", 4'd15, 1);
      run_read("rd2wrap", 4'd15, 2);

      // Read under alternating backpressure
      rdy_mode = 1;
      run_read("rd_toggle", 4'd6, 2);
      rdy_mode = 0;

      // Zero-length transfer
      en0 = en_count; d0 = done_count;
      start_xfer(1'b1, 4'd2, 5'd0);
      chk("zero_done_now", 64'(done), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("zero_done_cnt", 64'(done_count - d0), 1);
      chk("zero_no_bram", 64'(en_count - en0), 0);
      chk("zero_idle", 64'(busy), 0);

      // Early tlast on beat 2 (and correct tlast on beat 4)
      bd.delete(); bl.delete();
      for (int j = 0; j < 4; j++) begin bd.push_back(WW'($urandom)); bl.push_back(j == 1 || j == 3); end
      run_write("early_tlast", 4'd7, 1, 1);

      // Reset after two of four beats
      fill_beats(8, 0);
      d0 = done_count; wr0 = wr_count;
      start_xfer(1'b1, 4'd5, 5'd2);
      send_beat(bd[0], 1'b0, 0);
      send_beat(bd[1], 1'b0, 0);
      #2 rstn = 1'b0;
      #1 check_outputs_zero("midreset");
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      chk("midreset_no_write", 64'(wr_count - wr0), 0);
      chk("midreset_no_done", 64'(done_count - d0), 0);
      fill_beats(4, 0);
      run_write("after_reset", 4'd9, 1, 1);

      // Randomized mixed traffic
      for (int it = 0; it < 10; it++) begin
         n = $urandom_range(1, 3);
         if ($urandom_range(0, 1) == 1) begin
            fill_beats(n * WPL, 15);
            run_write("rand_wr", AW'($urandom), n, 2);
         end else begin
            rdy_mode = $urandom_range(0, 2);
            run_read("rand_rd", AW'($urandom), n);
            rdy_mode = 0;
         end
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
